microseq_addr_reg: RTL and testbench
====================================

Name: microseq_addr_reg

Overview:
- Microprogram sequencer that consumes the 2-bit next-address select {m1,m0} produced by the next-state selector.
- Holds the current control-store address and maintains its incrementer register.
- Adds memory-wait stalling on MOC, a one-level micro-subroutine link register, and a MOC watchdog that traps to an error microstate.
- Output state addresses the control-store ROM; the ROM's pipeline field feeds pipe_addr back into this block.

Parameters:
- ADDR_W, 8, width of the microstate address.
- RESET_STATE, 0, microstate loaded on reset.
- FETCH_STATE, 1, constant address selected by {m1,m0}=01.
- ERR_STATE, 2^ADDR_W-1, microstate forced on watchdog expiry.
- TIMEOUT, 16, stalled cycles allowed before a watchdog trap (>=1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- m0  in  1  select LSB.
- m1  in  1  select MSB.
- enc_addr  in  ADDR_W  microstate from the instruction encoder.
- pipe_addr  in  ADDR_W  next-state field of the current microinstruction.
- mem_req  in  1  current microinstruction waits for memory completion.
- moc  in  1  memory operation complete.
- call  in  1  current transition is a micro-subroutine call.
- ret  in  1  current transition is a return; overrides {m1,m0}.
- state  out  ADDR_W  current control-store address.
- link  out  ADDR_W  saved return address.
- stalled  out  1  combinational: mem_req & ~moc & ~reset.
- mem_err  out  1  one-cycle pulse on watchdog trap.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, and has priority over everything.
- Reset values:
  - state = RESET_STATE
  - incr = RESET_STATE+1 (mod 2^ADDR_W)
  - link = 0
  - wdog = 0
  - mem_err = 0
- Next-address mux, sel = {m1,m0}:
  - 00 → enc_addr
  - 01 → FETCH_STATE
  - 10 → pipe_addr
  - 11 → incr
- incr register: on every state update, incr <= next+1, truncated to ADDR_W. Invariant: incr == state+1 mod 2^ADDR_W; all-ones wraps to 0.
- Advance condition: adv = ~mem_req | moc. On adv, state <= next one cycle later; latency select→state is 1 clk.
- Stall (mem_req & ~moc):
  - state, incr and link hold.
  - wdog increments.
  - call/ret are ignored.
- ret=1 on an advancing cycle: next = link, {m1,m0} ignored, link unchanged.
- call=1 & ret=0 on an advancing cycle: next from sel; link <= incr (address after the call site).
- call and ret both 1: ret wins; link unchanged.
- Watchdog:
  - wdog clears on any advancing cycle and on reset.
  - When a stall cycle would make wdog reach TIMEOUT: state <= ERR_STATE, incr <= ERR_STATE+1, mem_err=1 for that next cycle only, wdog <= 0.
  - link is preserved across a trap.
  - If moc rises in the same cycle the count would expire, moc wins: normal advance, no trap.
- mem_err is registered and is 0 in all other cycles.
- Reset mid-stall: abandons the wait; wdog cleared; no mem_err.
- No X-propagation: all registers are defined from reset. Outputs are valid in the first cycle after reset deasserts.

Test Plan:
- Reset then sel=11 for 4 clks → state 0→1→2→3→4; incr tracks state+1.
- Sequence 01, 10 with pipe_addr=0x40, then 00 with enc_addr=0x80 → state=0x01, 0x40, 0x80.
- mem_req=1, moc=0 for 3 clks, then moc=1 with sel=11 from state 0x10 → state holds 0x10 with stalled=1 for 3 clks, then 0x11; mem_err stays 0.
- mem_req=1, moc=0 held with TIMEOUT=16 → after 16 stall cycles state=0xFF, mem_err=1 for exactly 1 clk, wdog=0. Variant with moc asserted on the 16th stall cycle → no trap.
- From state 0x20: call=1, sel=10, pipe_addr=0x50 → state 0x50, link 0x21. Later ret=1 with sel=01 → state 0x21. A stalled cycle with call=1 leaves link unchanged.
- state=0xFF with sel=11 → state 0x00. Reset asserted mid-stall at wdog=10 → state=RESET_STATE, mem_err 0.

Source files
------------

// File: rtl/microseq_addr_reg_if.sv
// ============================================================================
// Module   : microseq_addr_reg_if
// Brief    : Select, address and handshake bundle of the microsequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface microseq_addr_reg_if #(
  parameter int ADDR_W = 8
);
  logic              m0;
  logic              m1;
  logic [ADDR_W-1:0] enc_addr;
  logic [ADDR_W-1:0] pipe_addr;
  logic              mem_req;
  logic              moc;
  logic              call;
  logic              ret;
  logic [ADDR_W-1:0] state;
  logic [ADDR_W-1:0] link;
  logic              stalled;
  logic              mem_err;

  modport master (
    output m0, m1, enc_addr, pipe_addr, mem_req, moc, call, ret,
    input  state, link, stalled, mem_err
  );

  modport slave (
    input  m0, m1, enc_addr, pipe_addr, mem_req, moc, call, ret,
    output state, link, stalled, mem_err
  );
endinterface

`default_nettype wire

// File: rtl/microseq_addr_reg.sv
// ============================================================================
// Module   : microseq_addr_reg
// Brief    : Microprogram address register with MOC stall, one-level link
//            register and a MOC watchdog that traps to an error microstate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module microseq_addr_reg #(
  parameter int                ADDR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_STATE = '0,
  parameter logic [ADDR_W-1:0] FETCH_STATE = ADDR_W'(1),
  parameter logic [ADDR_W-1:0] ERR_STATE   = '1,
  parameter int                TIMEOUT     = 16
) (
  input wire                 clk,
  input wire                 reset,
  microseq_addr_reg_if.slave bus
);

  localparam int              WDOG_W    = $clog2(TIMEOUT + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  logic [ADDR_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0] incr_q,  incr_d;
  logic [ADDR_W-1:0] link_q,  link_d;
  logic [WDOG_W-1:0] wdog_q,  wdog_d;
  logic              mem_err_q, mem_err_d;

  logic [1:0]        sel;
  logic              adv;
  logic [ADDR_W-1:0] next_addr;

  assign sel = {bus.m1, bus.m0};
  assign adv = ~bus.mem_req | bus.moc;

  always_comb begin
    next_addr = incr_q;
    if (bus.ret) begin
      next_addr = link_q;
    end else begin
      case (sel)
        2'b00:   next_addr = bus.enc_addr;
        2'b01:   next_addr = FETCH_STATE;
        2'b10:   next_addr = bus.pipe_addr;
        default: next_addr = incr_q;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    incr_d    = incr_q;
    link_d    = link_q;
    wdog_d    = wdog_q;
    mem_err_d = 1'b0;
    if (adv) begin
      state_d = next_addr;
      incr_d  = next_addr + ONE;
      wdog_d  = '0;
      // The link captures the address after the call site, not the target.
      if (bus.call && !bus.ret) begin
        link_d = incr_q;
      end
    end else if (wdog_q == WDOG_LAST) begin
      state_d   = ERR_STATE;
      incr_d    = ERR_STATE + ONE;
      wdog_d    = '0;
      mem_err_d = 1'b1;
    end else begin
      wdog_d = wdog_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= RESET_STATE;
      incr_q    <= RESET_STATE + ONE;
      link_q    <= '0;
      wdog_q    <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      incr_q    <= incr_d;
      link_q    <= link_d;
      wdog_q    <= wdog_d;
      mem_err_q <= mem_err_d;
    end
  end

  assign bus.state   = state_q;
  assign bus.link    = link_q;
  assign bus.mem_err = mem_err_q;
  assign bus.stalled = bus.mem_req & ~bus.moc & ~reset;

endmodule

`default_nettype wire

// File: tb/tb_microseq_addr_reg.sv
// ============================================================================
// Module   : tb_microseq_addr_reg
// Brief    : Directed and randomized checks of microseq_addr_reg.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_microseq_addr_reg;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 16;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [7:0] m_state;
  logic [7:0] m_link;
  int         m_wdog;
  logic       m_err;

  microseq_addr_reg_if #(.ADDR_W(ADDR_W)) bus ();

  microseq_addr_reg #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: next values derived from the address rules, applied one clock later.
  task automatic tick();
    logic [7:0] ns, nl;
    logic       ne;
    int         nw;
    ns = m_state; nl = m_link; nw = m_wdog; ne = 1'b0;
    if (reset) begin
      ns = 8'h00; nl = 8'h00; nw = 0;
    end else if (!bus.mem_req || bus.moc) begin
      if (bus.ret) ns = m_link;
      else begin
        case ({bus.m1, bus.m0})
          2'd0:    ns = bus.enc_addr;
          2'd1:    ns = 8'h01;
          2'd2:    ns = bus.pipe_addr;
          default: ns = 8'((m_state + 1) % 256);
        endcase
      end
      if (bus.call && !bus.ret) nl = 8'((m_state + 1) % 256);
      nw = 0;
    end else begin
      nw = m_wdog + 1;
      if (nw >= TIMEOUT) begin ns = 8'hFF; nw = 0; ne = 1'b1; end
    end
    @(posedge clk); #1;
    m_state = ns; m_link = nl; m_wdog = nw; m_err = ne;
  endtask

  task automatic drive(input logic [1:0] s, input logic mr, input logic mc,
                       input logic c, input logic r);
    {bus.m1, bus.m0} = s;
    bus.mem_req = mr; bus.moc = mc; bus.call = c; bus.ret = r;
    #1;
  endtask

  task automatic test_reset();
    drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    n_checks++; if (bus.stalled !== 1'b0) begin n_fail++; $display("FAIL reset_stalled got=%b exp=0", bus.stalled); end
    tick(); tick();
    n_checks++; if (bus.state !== 8'h00) begin n_fail++; $display("FAIL reset_state got=%h exp=00", bus.state); end
    n_checks++; if (bus.link !== 8'h00) begin n_fail++; $display("FAIL reset_link got=%h exp=00", bus.link); end
    n_checks++; if (bus.mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_mem_err got=%b exp=0", bus.mem_err); end
    reset = 1'b0;
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_increment();
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_checks++; if (bus.state !== 8'(i)) begin n_fail++; $display("FAIL incr_step%0d got=%h exp=%h", i, bus.state, 8'(i)); end
    end
  endtask

  task automatic test_mux();
    drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    n_checks++; if (bus.state !== 8'h01) begin n_fail++; $display("FAIL mux_fetch got=%h exp=01", bus.state); end
    bus.pipe_addr = 8'h40; drive(2'b10, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    n_checks++; if (bus.state !== 8'h40) begin n_fail++; $display("FAIL mux_pipe got=%h exp=40", bus.state); end
    bus.enc_addr = 8'h80; drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    n_checks++; if (bus.state !== 8'h80) begin n_fail++; $display("FAIL mux_enc got=%h exp=80", bus.state); end
  endtask

  task automatic test_stall();
    bus.pipe_addr = 8'h10; drive(2'b10, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus.stalled !== 1'b1) begin n_fail++; $display("FAIL stall_flag%0d got=%b exp=1", i, bus.stalled); end
      tick();
      n_checks++; if (bus.state !== 8'h10 || bus.mem_err !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d state=%h err=%b exp=10/0", i, bus.state, bus.mem_err); end
    end
    drive(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++; if (bus.stalled !== 1'b0) begin n_fail++; $display("FAIL stall_moc_flag got=%b exp=0", bus.stalled); end
    tick();
    n_checks++; if (bus.state !== 8'h11 || bus.mem_err !== 1'b0) begin n_fail++; $display("FAIL stall_release state=%h err=%b exp=11/0", bus.state, bus.mem_err); end
  endtask

  task automatic stall_run(input int n, input string tag);
    drive(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      logic [7:0] held;
      held = bus.state;
      tick();
      n_checks++; if (bus.state !== held || bus.mem_err !== 1'b0) begin n_fail++; $display("FAIL %s_hold%0d state=%h err=%b exp=%h/0", tag, i, bus.state, bus.mem_err, held); end
    end
  endtask

  task automatic test_watchdog();
    drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    stall_run(TIMEOUT - 1, "wd_a");
    tick();
    n_checks++; if (bus.state !== 8'hFF || bus.mem_err !== 1'b1) begin n_fail++; $display("FAIL wd_trap state=%h err=%b exp=ff/1", bus.state, bus.mem_err); end
    // Count restarts from zero after the trap.
    stall_run(TIMEOUT - 1, "wd_b");
    tick();
    n_checks++; if (bus.state !== 8'hFF || bus.mem_err !== 1'b1) begin n_fail++; $display("FAIL wd_retrap state=%h err=%b exp=ff/1", bus.state, bus.mem_err); end
    drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    n_checks++; if (bus.state !== 8'h01 || bus.mem_err !== 1'b0) begin n_fail++; $display("FAIL wd_recover state=%h err=%b exp=01/0", bus.state, bus.mem_err); end
    stall_run(TIMEOUT - 1, "wd_c");
    drive(2'b11, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    n_checks++; if (bus.state !== 8'h02 || bus.mem_err !== 1'b0) begin n_fail++; $display("FAIL wd_moc_wins state=%h err=%b exp=02/0", bus.state, bus.mem_err); end
  endtask

  task automatic test_call_ret();
    bus.pipe_addr = 8'h20; drive(2'b10, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    bus.pipe_addr = 8'h50; drive(2'b10, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    n_checks++; if (bus.state !== 8'h50 || bus.link !== 8'h21) begin n_fail++; $display("FAIL call state=%h link=%h exp=50/21", bus.state, bus.link); end
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    bus.pipe_addr = 8'h99; drive(2'b10, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    n_checks++; if (bus.state !== 8'h51 || bus.link !== 8'h21) begin n_fail++; $display("FAIL call_stalled state=%h link=%h exp=51/21", bus.state, bus.link); end
    drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b1); tick();
    n_checks++; if (bus.state !== 8'h21 || bus.link !== 8'h21) begin n_fail++; $display("FAIL ret state=%h link=%h exp=21/21", bus.state, bus.link); end
    bus.pipe_addr = 8'h33; drive(2'b10, 1'b0, 1'b0, 1'b1, 1'b0); tick();
    drive(2'b10, 1'b0, 1'b0, 1'b1, 1'b1); tick();
    n_checks++; if (bus.state !== 8'h22 || bus.link !== 8'h22) begin n_fail++; $display("FAIL call_ret_both state=%h link=%h exp=22/22", bus.state, bus.link); end
  endtask

  task automatic test_wrap_reset();
    bus.pipe_addr = 8'hFF; drive(2'b10, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    drive(2'b11, 1'b0, 1'b0, 1'b0, 1'b0); tick();
    n_checks++; if (bus.state !== 8'h00) begin n_fail++; $display("FAIL wrap got=%h exp=00", bus.state); end
    tick();
    n_checks++; if (bus.state !== 8'h01) begin n_fail++; $display("FAIL wrap_next got=%h exp=01", bus.state); end
    stall_run(10, "rst_pre");
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (bus.state !== 8'h00 || bus.mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_mid_stall state=%h err=%b exp=00/0", bus.state, bus.mem_err); end
    stall_run(TIMEOUT - 1, "rst_post");
    tick();
    n_checks++; if (bus.state !== 8'hFF || bus.mem_err !== 1'b1) begin n_fail++; $display("FAIL reset_wdog_clear state=%h err=%b exp=ff/1", bus.state, bus.mem_err); end
    drive(2'b01, 1'b0, 1'b0, 1'b0, 1'b0); tick();
  endtask

  task automatic test_random();
    logic mr;
    mr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) mr = ~mr;
      bus.enc_addr  = 8'($urandom);
      bus.pipe_addr = 8'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      drive(2'($urandom), mr, ($urandom_range(0, 24) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0));
      n_checks++; if (bus.stalled !== (bus.mem_req & ~bus.moc & ~reset)) begin n_fail++; $display("FAIL rnd_stalled cyc=%0d got=%b", i, bus.stalled); end
      tick();
      n_checks++;
      if (bus.state !== m_state || bus.link !== m_link || bus.mem_err !== m_err) begin
        n_fail++;
        $display("FAIL rnd cyc=%0d state=%h link=%h err=%b exp=%h/%h/%b", i, bus.state, bus.link, bus.mem_err, m_state, m_link, m_err);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_state = 8'h00; m_link = 8'h00; m_wdog = 0; m_err = 1'b0;
    reset = 1'b1;
    bus.enc_addr = 8'h00; bus.pipe_addr = 8'h00;
    drive(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_increment();
    test_mux();
    test_stall();
    test_watchdog();
    test_call_ret();
    test_wrap_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
